// File: rtl/sonar_dsp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sonar_dsp_pkg : default DSP widths and saturation limits for the sonar   |
// | receive path.                                      Revision: 1.0         |
// +--------------------------------------------------------------------------+
package sonar_dsp_pkg;

  localparam int c_dw         = 16;
  localparam int c_gw         = 16;
  localparam int c_frac       = 12;
  localparam int c_ow         = 16;
  localparam int c_gain_unity = 1 << c_frac;

  // Largest / smallest value representable in an ow-bit two's complement word.
  function automatic longint sat_limit(input int ow, input bit want_max);
    longint w_one;
    w_one = longint'(1) << (ow - 1);
    return want_max ? (w_one - longint'(1)) : -w_one;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_round : round-half-up, arithmetic right shift by FRAC, then clip to  |
// | OW bits with a clip flag. Purely combinational.    Revision: 1.0         |
// +--------------------------------------------------------------------------+
module sat_round
  import sonar_dsp_pkg::*;
#(
  parameter int IW   = 32,
  parameter int FRAC = 12,
  parameter int OW   = 16
) (
  input  logic signed [IW-1:0] i_prod,
  output logic signed [OW-1:0] o_data,
  output logic                 o_sat
);

  // One guard bit above the product so adding the half-LSB can never wrap.
  localparam int c_rw = IW + 1;
  localparam logic signed [c_rw-1:0] c_max = c_rw'(sat_limit(OW, 1'b1));
  localparam logic signed [c_rw-1:0] c_min = c_rw'(sat_limit(OW, 1'b0));

  logic signed [c_rw-1:0] w_ext;
  logic signed [c_rw-1:0] w_half;
  logic signed [c_rw-1:0] w_sum;
  logic signed [c_rw-1:0] w_shift;

  assign w_ext = c_rw'(i_prod);

  if (FRAC > 0) begin : g_round
    assign w_half = c_rw'(1) <<< (FRAC - 1);
  end else begin : g_no_round
    assign w_half = '0;
  end

  assign w_sum   = w_ext + w_half;
  assign w_shift = w_sum >>> FRAC;

  always_comb begin
    o_sat  = 1'b0;
    o_data = w_shift[OW-1:0];
    if (w_shift > c_max) begin
      o_sat  = 1'b1;
      o_data = c_max[OW-1:0];
    end else if (w_shift < c_min) begin
      o_sat  = 1'b1;
      o_data = c_min[OW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/gain_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gain_stage_pipe : 3-stage signed Q-format gain with rounding, saturation |
// | and valid/ready backpressure.                      Revision: 1.0         |
// +--------------------------------------------------------------------------+
module gain_stage_pipe
  import sonar_dsp_pkg::*;
#(
  parameter int DW   = c_dw,
  parameter int GW   = c_gw,
  parameter int FRAC = c_frac,
  parameter int OW   = c_ow
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [DW-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic signed [GW-1:0] gain_i,
  input  logic                 gain_load_i,
  input  logic                 bypass_i,
  output logic signed [OW-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sat_o,
  output logic                 sat_sticky_o,
  input  logic                 clr_sat_i
);

  localparam int c_pw = DW + GW;
  localparam logic signed [GW-1:0] c_unity = GW'(1 << FRAC);

  logic signed [GW-1:0]   r_gain;
  logic                   r_s0_valid;
  logic signed [DW-1:0]   r_s0_data;
  logic signed [GW-1:0]   r_s0_gain;
  logic                   r_s1_valid;
  logic signed [c_pw-1:0] r_s1_prod;

  logic                   w_adv;
  logic                   w_out_xfer;
  logic signed [c_pw-1:0] w_prod;
  logic signed [OW-1:0]   w_rnd_data;
  logic                   w_rnd_sat;

  // The whole pipe moves as one unit; only a held output word can stall it.
  assign w_adv      = !(valid_o && !ready_i);
  assign ready_o    = w_adv;
  assign w_out_xfer = valid_o && ready_i;
  assign w_prod     = c_pw'(r_s0_data) * c_pw'(r_s0_gain);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gain <= c_unity;
    end else if (gain_load_i) begin
      r_gain <= gain_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
      r_s0_gain  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      sat_o      <= 1'b0;
    end else if (w_adv) begin
      r_s0_valid <= valid_i;
      if (valid_i) begin
        r_s0_data <= data_i;
        // Gain is captured with the sample so later loads never touch it.
        r_s0_gain <= bypass_i ? c_unity : r_gain;
      end
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_prod <= w_prod;
      end
      valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        data_o <= w_rnd_data;
      end
      sat_o <= r_s1_valid && w_rnd_sat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_sticky_o <= 1'b0;
    end else if (w_out_xfer && sat_o) begin
      sat_sticky_o <= 1'b1;
    end else if (clr_sat_i) begin
      sat_sticky_o <= 1'b0;
    end
  end

  sat_round #(
    .IW   (c_pw),
    .FRAC (FRAC),
    .OW   (OW)
  ) u_sat_round (
    .i_prod (r_s1_prod),
    .o_data (w_rnd_data),
    .o_sat  (w_rnd_sat)
  );

endmodule
`default_nettype wire
